vend_ctrl: RTL and testbench
============================

# vend_ctrl

Parametrised vending-machine controller that accumulates coin credit, issues a vend when credit reaches a configurable price, and returns change or a full refund through a handshaked change port. It is the configurable successor to the fixed 15-cent nickel/dime Mealy controller. Compared with that controller, it adds a quarter input, cancel/refund, change computation, vend and change acknowledgements, and coin rejection. It sits between the coin-acceptor debounce logic and the dispense/change-return actuators.

## Interface
- PRICE, 15: item price in cents; must satisfy 1 ≤ PRICE ≤ 2^CREDIT_W − 1 − Q_VAL.
- N_VAL, 5: credit value of the nickel input, in cents.
- D_VAL, 10: credit value of the dime input, in cents.
- Q_VAL, 25: credit value of the quarter input, in cents.
- CREDIT_W, 8: width of the credit and change datapaths.
- Clk  in  1  clock; all logic updates on the rising edge.
- Reset  in  1  reset Reset, synchronous, active-high; clock Clk.
- N, D, Q  in  1 each  coin-accepted strobes, one cycle per coin.
- Cancel  in  1  refund request.
- vend_ack  in  1  dispenser has taken the vend.
- change_ack  in  1  change mechanism has consumed change_amt.
- Open  out  1  vend request, held until acknowledged.
- change_valid  out  1  change_amt is valid.
- change_amt  out  CREDIT_W  change or refund value, in cents.
- credit  out  CREDIT_W  current accumulated credit.
- coin_reject  out  1  one-cycle pulse: the sampled coin was not credited.
- busy  out  1  high in VEND and CHANGE.

## Operation
- States: IDLE (credit 0), ACCUM (0 < credit < PRICE), VEND, CHANGE. All outputs are registered.
- Coin priority when several strobes are high in the same cycle: Q, then D, then N.
  - Only the winning coin is credited.
  - The losing coins are ignored silently, with no coin_reject.
- IDLE or ACCUM, no Cancel, coin present: credit is increased by the coin value.
  - If credit ≥ PRICE: go to VEND and set Open=1.
  - Otherwise: go to (or stay in) ACCUM.
- IDLE or ACCUM, Cancel=1, credit > 0:
  - Go to CHANGE with change_amt = credit and credit = 0. Open is never asserted.
  - A coin in the same cycle is not credited and pulses coin_reject.
- Cancel while credit = 0 is ignored, and any coin in that cycle is credited normally.
- VEND: hold Open=1 until vend_ack. On vend_ack, Open=0 and rem = credit − PRICE.
  - rem > 0: go to CHANGE with change_amt = rem.
  - rem = 0: go to IDLE.
  - In both cases, credit = 0.
- CHANGE: hold change_valid=1 and change_amt stable until change_ack.
  - On change_ack: go to IDLE with change_valid=0 and change_amt=0.
- Coins in VEND or CHANGE are not credited and pulse coin_reject. Cancel is ignored in these states.
- vend_ack outside VEND and change_ack outside CHANGE are ignored.
- Arithmetic is unsigned, CREDIT_W bits. Credit never exceeds PRICE − 1 + max(N_VAL, D_VAL, Q_VAL), so it cannot overflow under the PRICE constraint.
- Default state (illegal encoding): go to IDLE with all outputs cleared.

## Timing
- Reset, sampled high at an edge: after that edge, state=IDLE and every output is 0.
  - Affected outputs: Open, change_valid, change_amt, credit, coin_reject, busy.
  - Reset has priority over every other input in every state, including mid-VEND and mid-CHANGE; no change is output for the aborted transaction.
- Coin sampled at edge k: credit is updated after edge k. If the price is reached, Open=1 and busy=1 are also visible after edge k (1-cycle latency).
- vend_ack sampled at edge k:
  - Open=0 after edge k.
  - If change is owed, change_valid=1 after edge k.
  - Back-to-back acks are permitted, giving a minimum VEND residency of 1 cycle.
- change_ack sampled at edge k: change_valid=0 and state=IDLE after edge k. A coin is accepted at edge k+1.
- coin_reject is high for exactly the cycle following the rejected coin's edge.
- Cancel sampled at edge k: change_valid=1 after edge k.

## Test plan
- Defaults. Stimulus: N, N, N on consecutive cycles.
  - Required: credit 5 → 10, then Open=1.
  - Then vend_ack gives Open=0, change_valid stays 0, state is IDLE.
- Defaults. Stimulus: single Q.
  - Required: Open=1 the next cycle.
  - vend_ack gives change_valid=1 with change_amt=10.
  - change_ack gives change_valid=0 and credit=0.
- Defaults. Stimulus: D, then Cancel.
  - Required: change_amt=10 and change_valid=1; Open stays 0 throughout.
- Stimulus: coin N during VEND with vend_ack held low.
  - Required: coin_reject pulses for 1 cycle, Open stays 1.
  - Final change after vend_ack is unaffected.
- Stimulus: N and D asserted together from IDLE.
  - Required: credit=10, no coin_reject.
- Stimulus: PRICE=40, CREDIT_W=7. Q, Q, then vend_ack.
  - Required: change_amt=10.
  - Then Reset asserted mid-CHANGE: all outputs 0 and state IDLE after that edge.

Source files
------------

// File: rtl/vend_ctrl.sv
// Vending-machine controller: accumulates coin credit, requests a vend at PRICE,
// and returns change or a refund through a valid/ack change port.
module vend_ctrl #(
    parameter int PRICE    = 15,
    parameter int N_VAL    = 5,
    parameter int D_VAL    = 10,
    parameter int Q_VAL    = 25,
    parameter int CREDIT_W = 8
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                N,
    input  logic                D,
    input  logic                Q,
    input  logic                Cancel,
    input  logic                vend_ack,
    input  logic                change_ack,
    output logic                Open,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amt,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                busy
);

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] N_C     = CREDIT_W'(N_VAL);
    localparam logic [CREDIT_W-1:0] D_C     = CREDIT_W'(D_VAL);
    localparam logic [CREDIT_W-1:0] Q_C     = CREDIT_W'(Q_VAL);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_VEND,
        S_CHANGE
    } state_t;

    state_t              state_reg;
    logic                coin_any;
    logic [CREDIT_W-1:0] coin_val;
    logic [CREDIT_W-1:0] credit_sum;
    logic [CREDIT_W-1:0] rem;

    // Simultaneous strobes: the most valuable coin wins, the others are dropped.
    always_comb begin
        coin_any   = N | D | Q;
        coin_val   = Q ? Q_C : (D ? D_C : (N ? N_C : '0));
        credit_sum = credit + coin_val;
        rem        = credit - PRICE_C;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg    <= S_IDLE;
            Open         <= 1'b0;
            change_valid <= 1'b0;
            change_amt   <= '0;
            credit       <= '0;
            coin_reject  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            coin_reject <= 1'b0;
            case (state_reg)
                S_IDLE, S_ACCUM: begin
                    if (Cancel && credit != '0) begin
                        // Refund takes precedence; a coin arriving with it is bounced.
                        state_reg    <= S_CHANGE;
                        change_valid <= 1'b1;
                        change_amt   <= credit;
                        credit       <= '0;
                        busy         <= 1'b1;
                        coin_reject  <= coin_any;
                    end else if (coin_any) begin
                        credit <= credit_sum;
                        if (credit_sum >= PRICE_C) begin
                            state_reg <= S_VEND;
                            Open      <= 1'b1;
                            busy      <= 1'b1;
                        end else begin
                            state_reg <= S_ACCUM;
                        end
                    end
                end
                S_VEND: begin
                    coin_reject <= coin_any;
                    if (vend_ack) begin
                        Open   <= 1'b0;
                        credit <= '0;
                        if (rem != '0) begin
                            state_reg    <= S_CHANGE;
                            change_valid <= 1'b1;
                            change_amt   <= rem;
                        end else begin
                            state_reg <= S_IDLE;
                            busy      <= 1'b0;
                        end
                    end
                end
                S_CHANGE: begin
                    coin_reject <= coin_any;
                    if (change_ack) begin
                        state_reg    <= S_IDLE;
                        change_valid <= 1'b0;
                        change_amt   <= '0;
                        busy         <= 1'b0;
                    end
                end
                default: begin
                    state_reg    <= S_IDLE;
                    Open         <= 1'b0;
                    change_valid <= 1'b0;
                    change_amt   <= '0;
                    credit       <= '0;
                    coin_reject  <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: directed scenarios on a default and a
// PRICE=40 instance, plus randomized traffic checked against a credit model.
module tb_vend_ctrl;

    localparam int PRICE = 15;
    localparam int NV = 5, DV = 10, QV = 25;

    logic       clk = 1'b0;
    logic       reset = 1'b0, n = 1'b0, d = 1'b0, q = 1'b0, cancel = 1'b0;
    logic       vack = 1'b0, cack = 1'b0;
    logic       open_a, cv_a, rej_a, busy_a;
    logic [7:0] amt_a, credit_a;
    logic       open_b, cv_b, rej_b, busy_b;
    logic [6:0] amt_b, credit_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vend_ctrl dut_a (
        .Clk(clk), .Reset(reset), .N(n), .D(d), .Q(q), .Cancel(cancel),
        .vend_ack(vack), .change_ack(cack), .Open(open_a), .change_valid(cv_a),
        .change_amt(amt_a), .credit(credit_a), .coin_reject(rej_a), .busy(busy_a)
    );

    vend_ctrl #(.PRICE(40), .CREDIT_W(7)) dut_b (
        .Clk(clk), .Reset(reset), .N(n), .D(d), .Q(q), .Cancel(cancel),
        .vend_ack(vack), .change_ack(cack), .Open(open_b), .change_valid(cv_b),
        .change_amt(amt_b), .credit(credit_b), .coin_reject(rej_b), .busy(busy_b)
    );

    // Apply one cycle of inputs {reset,n,d,q,cancel,vack,cack}, sample 1ns after the edge.
    task automatic drive(input logic [6:0] v);
        {reset, n, d, q, cancel, vack, cack} = v;
        @(posedge clk);
        #1;
        {reset, n, d, q, cancel, vack, cack} = 7'b0;
    endtask

    task automatic test_reset;
        drive(7'b1000000);
        checks++;
        if ({open_a, cv_a, amt_a, credit_a, rej_a, busy_a} !== 20'b0) begin
            errors++;
            $display("FAIL reset_a: got open=%b cv=%b amt=%0d credit=%0d rej=%b busy=%b, want all 0",
                     open_a, cv_a, amt_a, credit_a, rej_a, busy_a);
        end
        checks++;
        if ({open_b, cv_b, amt_b, credit_b, rej_b, busy_b} !== 18'b0) begin
            errors++;
            $display("FAIL reset_b: got open=%b cv=%b amt=%0d credit=%0d, want all 0",
                     open_b, cv_b, amt_b, credit_b);
        end
        $display("reset: outputs cleared");
    endtask

    task automatic test_nickels;
        drive(7'b0100000);
        checks++;
        if (credit_a !== 8'd5) begin errors++; $display("FAIL nickel1_credit: got %0d want 5", credit_a); end
        drive(7'b0100000);
        checks++;
        if (credit_a !== 8'd10 || open_a !== 1'b0) begin
            errors++; $display("FAIL nickel2: got credit=%0d open=%b want 10/0", credit_a, open_a);
        end
        drive(7'b0100000);
        checks++;
        if (open_a !== 1'b1 || busy_a !== 1'b1 || credit_a !== 8'd15) begin
            errors++; $display("FAIL nickel3_vend: got open=%b busy=%b credit=%0d want 1/1/15", open_a, busy_a, credit_a);
        end
        drive(7'b0000010);
        checks++;
        if (open_a !== 1'b0 || cv_a !== 1'b0 || busy_a !== 1'b0 || credit_a !== 8'd0) begin
            errors++; $display("FAIL nickel_ack: got open=%b cv=%b busy=%b credit=%0d want 0/0/0/0", open_a, cv_a, busy_a, credit_a);
        end
        $display("nickels: N N N vend, no change");
    endtask

    task automatic test_quarter;
        drive(7'b0001000);
        checks++;
        if (open_a !== 1'b1) begin errors++; $display("FAIL quarter_open: got %b want 1", open_a); end
        drive(7'b0000010);
        checks++;
        if (cv_a !== 1'b1 || amt_a !== 8'd10 || open_a !== 1'b0) begin
            errors++; $display("FAIL quarter_change: got cv=%b amt=%0d open=%b want 1/10/0", cv_a, amt_a, open_a);
        end
        drive(7'b0000001);
        checks++;
        if (cv_a !== 1'b0 || credit_a !== 8'd0 || amt_a !== 8'd0 || busy_a !== 1'b0) begin
            errors++; $display("FAIL quarter_cack: got cv=%b credit=%0d amt=%0d busy=%b want 0/0/0/0", cv_a, credit_a, amt_a, busy_a);
        end
        $display("quarter: vend, change 10 returned");
    endtask

    task automatic test_cancel;
        drive(7'b0010000);
        checks++;
        if (credit_a !== 8'd10) begin errors++; $display("FAIL cancel_dime: got credit=%0d want 10", credit_a); end
        drive(7'b0000100);
        checks++;
        if (cv_a !== 1'b1 || amt_a !== 8'd10 || open_a !== 1'b0 || credit_a !== 8'd0) begin
            errors++; $display("FAIL cancel_refund: got cv=%b amt=%0d open=%b credit=%0d want 1/10/0/0", cv_a, amt_a, open_a, credit_a);
        end
        drive(7'b0000001);
        $display("cancel: refund 10");
    endtask

    task automatic test_coin_in_vend;
        drive(7'b0010000);
        drive(7'b0010000);
        drive(7'b0100000);
        checks++;
        if (rej_a !== 1'b1 || open_a !== 1'b1 || credit_a !== 8'd20) begin
            errors++; $display("FAIL vend_coin_reject: got rej=%b open=%b credit=%0d want 1/1/20", rej_a, open_a, credit_a);
        end
        drive(7'b0000000);
        checks++;
        if (rej_a !== 1'b0 || open_a !== 1'b1) begin
            errors++; $display("FAIL vend_reject_pulse: got rej=%b open=%b want 0/1", rej_a, open_a);
        end
        drive(7'b0000010);
        checks++;
        if (cv_a !== 1'b1 || amt_a !== 8'd5) begin
            errors++; $display("FAIL vend_coin_change: got cv=%b amt=%0d want 1/5", cv_a, amt_a);
        end
        drive(7'b0000001);
        $display("coin in vend: rejected, change 5");
    endtask

    task automatic test_multi_coin;
        drive(7'b0110000);
        checks++;
        if (credit_a !== 8'd10 || rej_a !== 1'b0) begin
            errors++; $display("FAIL multi_coin: got credit=%0d rej=%b want 10/0", credit_a, rej_a);
        end
        drive(7'b0100100);
        checks++;
        if (rej_a !== 1'b1 || amt_a !== 8'd10 || cv_a !== 1'b1) begin
            errors++; $display("FAIL cancel_with_coin: got rej=%b amt=%0d cv=%b want 1/10/1", rej_a, amt_a, cv_a);
        end
        drive(7'b0000001);
        drive(7'b0010100);
        checks++;
        if (credit_a !== 8'd10 || rej_a !== 1'b0 || cv_a !== 1'b0) begin
            errors++; $display("FAIL cancel_zero_credit: got credit=%0d rej=%b cv=%b want 10/0/0", credit_a, rej_a, cv_a);
        end
        drive(7'b0000100);
        drive(7'b0000001);
        $display("multi coin: N+D credits 10, cancel paths ok");
    endtask

    task automatic test_price40;
        drive(7'b1000000);
        drive(7'b0001000);
        checks++;
        if (credit_b !== 7'd25 || open_b !== 1'b0) begin
            errors++; $display("FAIL p40_q1: got credit=%0d open=%b want 25/0", credit_b, open_b);
        end
        drive(7'b0001000);
        checks++;
        if (open_b !== 1'b1 || credit_b !== 7'd50) begin
            errors++; $display("FAIL p40_q2: got open=%b credit=%0d want 1/50", open_b, credit_b);
        end
        drive(7'b0000010);
        checks++;
        if (cv_b !== 1'b1 || amt_b !== 7'd10) begin
            errors++; $display("FAIL p40_change: got cv=%b amt=%0d want 1/10", cv_b, amt_b);
        end
        drive(7'b1000000);
        checks++;
        if ({open_b, cv_b, amt_b, credit_b, rej_b, busy_b} !== 18'b0) begin
            errors++; $display("FAIL p40_reset_mid_change: got cv=%b amt=%0d busy=%b want all 0", cv_b, amt_b, busy_b);
        end
        // A coin must be accepted normally once back in IDLE.
        drive(7'b0010000);
        checks++;
        if (credit_b !== 7'd10 || rej_b !== 1'b0) begin
            errors++; $display("FAIL p40_after_reset: got credit=%0d rej=%b want 10/0", credit_b, rej_b);
        end
        drive(7'b1000000);
        $display("price40: change 10, reset mid-change clears");
    endtask

    // Reference model: credit, pending vend, and owed change tracked in cents.
    task automatic test_random;
        int m_credit = 0, m_change = 0;
        bit m_vending = 0, m_cv = 0, m_rej = 0;
        int coin_val, transactions = 0;
        logic [6:0] v;
        logic [19:0] exp_v;
        for (int i = 0; i < 600; i++) begin
            v[6] = ($urandom_range(0, 99) < 2);
            v[5] = ($urandom_range(0, 99) < 20);
            v[4] = ($urandom_range(0, 99) < 15);
            v[3] = ($urandom_range(0, 99) < 10);
            v[2] = ($urandom_range(0, 99) < 6);
            v[1] = ($urandom_range(0, 99) < 35);
            v[0] = ($urandom_range(0, 99) < 35);
            coin_val = v[3] ? QV : (v[4] ? DV : (v[5] ? NV : 0));
            if (v[6]) begin
                m_credit = 0; m_change = 0; m_vending = 0; m_cv = 0; m_rej = 0;
            end else if (m_vending) begin
                m_rej = (coin_val != 0);
                if (v[1]) begin
                    m_vending = 0;
                    if (m_credit > PRICE) begin m_cv = 1; m_change = m_credit - PRICE; end
                    transactions++;
                    $display("random: vend at credit %0d, change %0d", m_credit, m_credit - PRICE);
                    m_credit = 0;
                end
            end else if (m_cv) begin
                m_rej = (coin_val != 0);
                if (v[0]) begin m_cv = 0; m_change = 0; end
            end else if (v[2] && m_credit > 0) begin
                m_rej = (coin_val != 0);
                m_cv = 1; m_change = m_credit; m_credit = 0;
                transactions++;
                $display("random: refund %0d", m_change);
            end else begin
                m_rej = 0;
                m_credit += coin_val;
                if (m_credit >= PRICE) m_vending = 1;
            end
            drive(v);
            exp_v = {m_vending, m_cv, 8'(m_change), 8'(m_credit), m_rej, m_vending | m_cv};
            checks++;
            if ({open_a, cv_a, amt_a, credit_a, rej_a, busy_a} !== exp_v) begin
                errors++;
                $display("FAIL random_cycle%0d: got open=%b cv=%b amt=%0d credit=%0d rej=%b busy=%b want open=%b cv=%b amt=%0d credit=%0d rej=%b busy=%b",
                         i, open_a, cv_a, amt_a, credit_a, rej_a, busy_a,
                         exp_v[19], exp_v[18], exp_v[17:10], exp_v[9:2], exp_v[1], exp_v[0]);
            end
        end
        $display("random: %0d vend/refund transactions", transactions);
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset;
        test_nickels;
        test_quarter;
        test_cancel;
        test_coin_in_vend;
        test_multi_coin;
        test_price40;
        drive(7'b1000000);
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
